// File: rtl/gray_step_decoder.sv
// gray_step_decoder: takes a stream of Gray-coded position samples and decodes
// each one to binary. It classifies the move from the previous sample as
// HOLD, UP, DOWN or ERR, and keeps a wrapping position count plus a saturating
// error count. A one-entry output register holds each result (latency 1), and
// a new result can replace the current one in the same cycle it drains.
module gray_step_decoder #(
   parameter int W     = 4,
   parameter int POS_W = 8,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     g_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_bin,
   output logic [W-1:0]     out_gray,
   output logic [1:0]       out_step,
   output logic             out_first,
   output logic [POS_W-1:0] pos,
   output logic [ERR_W-1:0] err_cnt
);

   localparam logic [0:0] S_IDLE  = 1'b0;  // no reference sample yet
   localparam logic [0:0] S_TRACK = 1'b1;  // out_bin holds the reference

   localparam logic [1:0] STEP_HOLD = 2'b00;
   localparam logic [1:0] STEP_UP   = 2'b01;
   localparam logic [1:0] STEP_DOWN = 2'b10;
   localparam logic [1:0] STEP_ERR  = 2'b11;

   logic [0:0]   state;
   logic         accept;
   logic [W-1:0] cur_bin;
   logic [W-1:0] diff;
   logic [1:0]   step;

   // Convert Gray to binary by a prefix XOR that runs from the MSB down.
   function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
      logic [W-1:0] b;
      b[W-1] = g[W-1];
      for (int i = W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // in_ready depends only on the output register, so g_in has no path to any output.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // Decode the incoming sample and classify it against the reference sample.
   // The reference is always the last accepted binary, which out_bin already
   // holds, so no separate register is needed. The modulo-2^W difference
   // covers the wrap cases without extra logic: 0 - all-ones is +1, and
   // all-ones - 0 is -1.
   always_comb begin
      cur_bin = gray2bin(g_in);
      diff    = cur_bin - out_bin;
      step    = STEP_ERR;
      if (diff == '0)
         step = STEP_HOLD;
      else if (diff == W'(1))
         step = STEP_UP;
      else if (diff == '1)
         step = STEP_DOWN;
   end

   // Output register: load on accept, drop valid when drained with nothing new.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_bin   <= '0;
         out_gray  <= '0;
         out_step  <= STEP_HOLD;
         out_first <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_bin   <= cur_bin;
         out_gray  <= g_in;
         out_step  <= (state == S_IDLE) ? STEP_HOLD : step;
         out_first <= (state == S_IDLE);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Tracking state: the first accepted sample after reset becomes the
   // reference. After that the decoder stays in TRACK, and it resyncs to each
   // new sample even after an error.
   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else if (accept)
         state <= S_TRACK;
   end

   // Position counter: wraps modulo 2^POS_W in both directions.
   always_ff @(posedge clk) begin
      if (rst) begin
         pos <= '0;
      end else if (accept && state == S_TRACK) begin
         if (step == STEP_UP)
            pos <= pos + POS_W'(1);
         else if (step == STEP_DOWN)
            pos <= pos - POS_W'(1);
      end
   end

   // Error counter: stops at all-ones so that a burst of errors never looks small.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (accept && state == S_TRACK && step == STEP_ERR && err_cnt != '1) begin
         err_cnt <= err_cnt + ERR_W'(1);
      end
   end

endmodule

// File: tb/tb_gray_step_decoder.sv
// Directed bench for gray_step_decoder. dut uses the default widths. dut2
// uses ERR_W=2 to check that the error counter saturates. Inputs change #1
// after a rising edge, and outputs are checked at that point.
module tb_gray_step_decoder;

   localparam logic [1:0] HOLD = 2'b00;
   localparam logic [1:0] UP   = 2'b01;
   localparam logic [1:0] DOWN = 2'b10;
   localparam logic [1:0] ERR  = 2'b11;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, out_ready, in_ready, out_valid, out_first;
   logic [3:0] g_in, out_bin, out_gray;
   logic [1:0] out_step;
   logic [7:0] pos, err_cnt;

   logic       in_valid2, out_ready2, in_ready2, out_valid2, out_first2;
   logic [3:0] g_in2, out_bin2, out_gray2;
   logic [1:0] out_step2;
   logic [7:0] pos2;
   logic [1:0] err_cnt2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   gray_step_decoder #(.W(4), .POS_W(8), .ERR_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .g_in(g_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin), .out_gray(out_gray),
      .out_step(out_step), .out_first(out_first), .pos(pos), .err_cnt(err_cnt)
   );

   gray_step_decoder #(.W(4), .POS_W(8), .ERR_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .g_in(g_in2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_bin(out_bin2), .out_gray(out_gray2),
      .out_step(out_step2), .out_first(out_first2), .pos(pos2), .err_cnt(err_cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one sample on dut and advance one clock.
   task automatic step(input logic v, input logic [3:0] g);
      in_valid = v;
      g_in     = g;
      @(posedge clk);
      #1;
   endtask

   // Check the full result register of dut.
   task automatic chk_res(input string tag, input logic [3:0] bin, input logic [3:0] gray,
                          input logic [1:0] st, input logic first,
                          input logic [7:0] p, input logic [7:0] e);
      chk({tag, ".valid"}, out_valid, 1'b1);
      chk({tag, ".bin"},   out_bin,   bin);
      chk({tag, ".gray"},  out_gray,  gray);
      chk({tag, ".step"},  out_step,  st);
      chk({tag, ".first"}, out_first, first);
      chk({tag, ".pos"},   pos,       p);
      chk({tag, ".err"},   err_cnt,   e);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; g_in = '0; out_ready = 1'b1;
      in_valid2 = 1'b0; g_in2 = '0; out_ready2 = 1'b1;

      // Reset state
      @(posedge clk); #1;
      chk("rst.valid", out_valid, 1'b0);
      chk("rst.bin",   out_bin,   4'd0);
      chk("rst.gray",  out_gray,  4'd0);
      chk("rst.step",  out_step,  HOLD);
      chk("rst.first", out_first, 1'b0);
      chk("rst.pos",   pos,       8'd0);
      chk("rst.err",   err_cnt,   8'd0);
      chk("rst.ready", in_ready,  1'b1);
      rst = 1'b0;

      // Count up
      step(1'b1, 4'b0000); chk_res("up0", 4'd0, 4'b0000, HOLD, 1'b1, 8'd0, 8'd0);
      step(1'b1, 4'b0001); chk_res("up1", 4'd1, 4'b0001, UP,   1'b0, 8'd1, 8'd0);
      step(1'b1, 4'b0011); chk_res("up2", 4'd2, 4'b0011, UP,   1'b0, 8'd2, 8'd0);
      step(1'b1, 4'b0010); chk_res("up3", 4'd3, 4'b0010, UP,   1'b0, 8'd3, 8'd0);

      // Wrap: 3->14 is non-adjacent, then 14->15->0 UP, 0->15 DOWN
      step(1'b1, 4'b1001); chk_res("w14", 4'd14, 4'b1001, ERR,  1'b0, 8'd3, 8'd1);
      step(1'b1, 4'b1000); chk_res("w15", 4'd15, 4'b1000, UP,   1'b0, 8'd4, 8'd1);
      step(1'b1, 4'b0000); chk_res("w0",  4'd0,  4'b0000, UP,   1'b0, 8'd5, 8'd1);
      step(1'b1, 4'b1000); chk_res("wdn", 4'd15, 4'b1000, DOWN, 1'b0, 8'd4, 8'd1);

      // Non-adjacent: 15->1 ERR, then Gray 0001->1001 (one bit, 1->14) ERR, resync UP
      step(1'b1, 4'b0001); chk_res("ne1",  4'd1,  4'b0001, ERR, 1'b0, 8'd4, 8'd2);
      step(1'b1, 4'b1001); chk_res("ne14", 4'd14, 4'b1001, ERR, 1'b0, 8'd4, 8'd3);
      step(1'b1, 4'b1000); chk_res("nrs",  4'd15, 4'b1000, UP,  1'b0, 8'd5, 8'd3);
      step(1'b1, 4'b0000); chk_res("p0",   4'd0,  4'b0000, UP,  1'b0, 8'd6, 8'd3);
      step(1'b1, 4'b0001); chk_res("p1",   4'd1,  4'b0001, UP,  1'b0, 8'd7, 8'd3);

      // Backpressure: the result holds and in_ready stays low while 0011 waits
      out_ready = 1'b0; in_valid = 1'b1; g_in = 4'b0011; #1;
      chk("bp.ready0", in_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("bp.ready", in_ready, 1'b0);
         chk_res("bp.hold", 4'd1, 4'b0001, UP, 1'b0, 8'd7, 8'd3);
      end
      out_ready = 1'b1; #1;
      chk("bp.release", in_ready, 1'b1);
      @(posedge clk); #1;
      chk_res("bp.take", 4'd2, 4'b0011, UP, 1'b0, 8'd8, 8'd3);
      step(1'b1, 4'b0010); chk_res("bp.next", 4'd3, 4'b0010, UP, 1'b0, 8'd9, 8'd3);
      step(1'b0, 4'b0111);
      chk("drain.valid", out_valid, 1'b0);
      chk("drain.pos",   pos,       8'd9);

      // Reach pos=5 from a fresh reset, then reset mid-stream with a sample offered
      rst = 1'b1; step(1'b0, 4'b0000); rst = 1'b0;
      step(1'b1, 4'b0000);
      step(1'b1, 4'b0001);
      step(1'b1, 4'b0011);
      step(1'b1, 4'b0010);
      step(1'b1, 4'b0110);
      step(1'b1, 4'b0111); chk_res("pre5", 4'd5, 4'b0111, UP, 1'b0, 8'd5, 8'd0);
      rst = 1'b1; step(1'b1, 4'b0110); rst = 1'b0;
      chk("mr.valid", out_valid, 1'b0);
      chk("mr.pos",   pos,       8'd0);
      chk("mr.err",   err_cnt,   8'd0);
      chk("mr.first", out_first, 1'b0);
      chk("mr.bin",   out_bin,   4'd0);
      step(1'b1, 4'b0110); chk_res("mr.hold", 4'd4, 4'b0110, HOLD, 1'b1, 8'd0,   8'd0);
      step(1'b1, 4'b0010); chk_res("pos.neg", 4'd3, 4'b0010, DOWN, 1'b0, 8'd255, 8'd0);
      step(1'b1, 4'b0110); chk_res("pos.pos", 4'd4, 4'b0110, UP,   1'b0, 8'd0,   8'd0);
      step(1'b1, 4'b0110); chk_res("hold",    4'd4, 4'b0110, HOLD, 1'b0, 8'd0,   8'd0);
      in_valid = 1'b0;

      // Saturation on dut2 (ERR_W=2): alternate bin 0 and bin 4
      in_valid2 = 1'b1; g_in2 = 4'b0000; @(posedge clk); #1;
      chk("sat.first", out_first2, 1'b1);
      chk("sat.cnt0",  err_cnt2,   2'd0);
      for (int i = 0; i < 5; i++) begin
         g_in2 = (i % 2 == 0) ? 4'b0110 : 4'b0000;
         @(posedge clk); #1;
         chk("sat.step", out_step2, ERR);
         chk("sat.cnt",  err_cnt2,  (i < 3) ? i + 1 : 3);
      end
      in_valid2 = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
